// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the sequential Booth multiplier.
//   MULT_N        default operand width
//   mult_state_e  FSM state encoding (IDLE, RUN)
package mult_pkg;

  localparam int MULT_N = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mult_state_e;

endpackage

// File: rtl/mult_booth_step.sv
// mult_booth_step: one radix-2 Booth iteration, purely combinational.
//   p_i  [2N:0]  accumulator {upper N, multiplier N, Booth bit}
//   a_i  [N-1:0] multiplicand (signed)
//   p_o  [2N:0]  accumulator after add/sub select and arithmetic shift right by 1
module mult_booth_step #(
  parameter int N = 32
) (
  input  logic [2*N:0] p_i,
  input  logic [N-1:0] a_i,
  output logic [2*N:0] p_o
);

  logic [N:0] up_ext;
  logic [N:0] a_ext;
  logic [N:0] sum;

  // The upper field is summed one bit wider than N. With A = -2^(N-1) a plain
  // N-bit subtract wraps to the wrong sign; the extra bit keeps the true sign
  // so the shift that follows brings it back into N bits exactly.
  always_comb begin
    up_ext = {p_i[2*N], p_i[2*N:N+1]};
    a_ext  = {a_i[N-1], a_i};
    sum    = up_ext;
    unique case (p_i[1:0])
      2'b01:   sum = up_ext + a_ext;
      2'b10:   sum = up_ext - a_ext;
      default: sum = up_ext;
    endcase
    // {sum, lower bits} dropped by one position == arithmetic shift right of
    // the updated accumulator; sum[N] supplies the sign-extended MSB.
    p_o = {sum, p_i[N:1]};
  end

endmodule

// File: rtl/mult.sv
// mult: sequential signed multiplier, {hi,lo} = srcA * srcB.
// Radix-2 Booth, one step per clock, N steps after the load edge.
//   clk       rising-edge clock
//   reset     synchronous, active-low
//   srcA/srcB signed operands, sampled on the start edge only
//   multCtrl  start request, honoured only in IDLE
//   hi/lo     upper/lower product halves, updated on the completion edge only
//   multDone  (only with MULT_DONE_EN defined) 1-cycle pulse on the completion edge
module mult
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] srcA,
  input  logic [N-1:0] srcB,
  input  logic         multCtrl,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
`ifdef MULT_DONE_EN
  ,
  output logic         multDone
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  mult_state_e  state_q;
  logic [N-1:0] a_q;
  logic [2*N:0] p_q, p_d;
  logic [CW-1:0] cnt_q;
  logic [N-1:0] hi_q, lo_q;
  logic         last_step;

  mult_booth_step #(.N(N)) u_step (
    .p_i (p_q),
    .a_i (a_q),
    .p_o (p_d)
  );

  assign last_step = (cnt_q == CW'(N - 1));

`ifdef MULT_DONE_EN
  logic done_q;
  assign multDone = done_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MULT_DONE_EN
      done_q  <= 1'b0;
`endif
    end else begin
`ifdef MULT_DONE_EN
      done_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (multCtrl) begin
            a_q     <= srcA;
            p_q     <= {{N{1'b0}}, srcB, 1'b0};
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          p_q   <= p_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_step) begin
            // Result taken from the freshly stepped accumulator so it lands on
            // the same edge as the final Booth step.
            hi_q    <= p_d[2*N:N+1];
            lo_q    <= p_d[N:1];
            state_q <= IDLE;
`ifdef MULT_DONE_EN
            done_q  <= 1'b1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mult.sv
// tb_mult: self-checking bench for mult (N=32). Table-driven vectors plus
// hand-written sequences for mid-run restart attempts and reset abort.
// Expected results go through a scoreboard queue: pushed at start, popped
// at the completion edge.
module tb_mult;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] srcA, srcB;
  logic         multCtrl;
  logic [N-1:0] hi, lo;
`ifdef MULT_DONE_EN
  logic         multDone;
`endif

  mult #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .srcA     (srcA),
    .srcB     (srcB),
    .multCtrl (multCtrl),
    .hi       (hi),
    .lo       (lo)
`ifdef MULT_DONE_EN
    ,
    .multDone (multDone)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
  } vec_t;

  logic [2*N-1:0] sb[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [2*N-1:0] act, input logic [2*N-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: sign-extend to 2N bits and multiply.
  function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] x, y;
    x = {{N{a[N-1]}}, a};
    y = {{N{b[N-1]}}, b};
    return x * y;
  endfunction

  // Start one multiply and follow it to completion.
  //   pulse : number of edges multCtrl stays high (1 or 2)
  //   inj   : if nonzero, edge index (in RUN) at which a 3*3 request is pulsed
  task automatic do_mult(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2*N-1:0] exp, input int pulse, input int inj);
    logic [2*N-1:0] prev, got;
    logic held;
    @(negedge clk);
    srcA = a; srcB = b; multCtrl = 1'b1;
    sb.push_back(exp);
    prev = {hi, lo};
    held = 1'b1;
    for (int e = 1; e <= N + 1; e++) begin
      @(posedge clk); #1;
      if (e == pulse) multCtrl = 1'b0;
      if (e == 1) begin srcA = ~a; srcB = b + 32'd7; end
      if (inj != 0 && e == inj) begin srcA = 32'd3; srcB = 32'd3; multCtrl = 1'b1; end
      if (inj != 0 && e == inj + 1) multCtrl = 1'b0;
      if (e <= N) begin
        if ({hi, lo} !== prev) held = 1'b0;
`ifdef MULT_DONE_EN
        if (multDone !== 1'b0) held = 1'b0;
`endif
      end
    end
    chk({name, "_hold"}, {63'd0, held}, 64'd1);
    got = sb.pop_front();
    chk({name, "_hi"}, {32'd0, hi}, {32'd0, got[2*N-1:N]});
    chk({name, "_lo"}, {32'd0, lo}, {32'd0, got[N-1:0]});
`ifdef MULT_DONE_EN
    chk({name, "_done"}, {63'd0, multDone}, 64'd1);
`endif
    @(posedge clk); #1;
    // Still IDLE with the old result and no spurious restart.
    chk({name, "_after"}, {hi, lo}, got);
  endtask

  vec_t vt[8];

  initial begin
    vt[0] = '{32'd26,         32'd30,         32'h0000_0000, 32'd780};
    vt[1] = '{32'hFFFF_FFF3,  32'd13,         32'hFFFF_FFFF, 32'hFFFF_FF57};
    vt[2] = '{32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000};
    vt[3] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0001};
    vt[4] = '{32'h7FFF_FFFF,  32'h8000_0000,  32'hC000_0000, 32'h8000_0000};
    vt[5] = '{32'h7FFF_FFFF,  32'h7FFF_FFFF,  32'h3FFF_FFFF, 32'h0000_0001};
    vt[6] = '{32'h0000_0000,  32'd12345,      32'h0000_0000, 32'h0000_0000};
    vt[7] = '{32'd12345,      32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_CFC7};

    reset = 1'b0; multCtrl = 1'b0; srcA = '0; srcB = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
`ifdef MULT_DONE_EN
    chk("reset_done", {63'd0, multDone}, 64'd0);
`endif
    reset = 1'b1;

    for (int i = 0; i < 8; i++)
      do_mult($sformatf("vec%0d", i), vt[i].a, vt[i].b, {vt[i].hi, vt[i].lo}, (i == 0) ? 2 : 1, 0);

    for (int i = 0; i < 6; i++) begin
      logic [N-1:0] ra, rb;
      ra = $urandom; rb = $urandom;
      if (i == 0) ra = 32'h8000_0000;
      if (i == 1) rb = 32'h8000_0000;
      do_mult($sformatf("rnd%0d", i), ra, rb, model(ra, rb), 1, 0);
    end

    // Mid-run 3*3 request must be ignored; 7*6 completes normally.
    do_mult("midrun", 32'd7, 32'd6, 64'd42, 1, 12);

    // Reset abort: load 5*5, reset sampled at the edge after step 10.
    @(negedge clk);
    srcA = 32'd5; srcB = 32'd5; multCtrl = 1'b1;
    @(posedge clk); #1;
    multCtrl = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_hi", {32'd0, hi}, 64'd0);
    chk("abort_lo", {32'd0, lo}, 64'd0);
    reset = 1'b1;
    repeat (N + 2) @(posedge clk);
    #1;
    // No leftover computation may complete after the abort.
    chk("abort_idle", {hi, lo}, 64'd0);
    do_mult("post_abort", 32'd5, 32'd5, 64'd25, 1, 0);

    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
